ets_phase_stepper: RTL and testbench

Upstream phase-control stage for the equivalent-time sampling (ETS) engine. It answers the engine's one-cycle `shift` request by stepping the sampling-clock MMCM fine phase through the PSEN/PSINCDEC/PSDONE dynamic-shift port, then returns a one-cycle `shift_done`. It tracks the current fine-phase index modulo one period and drives it as `vernier_q` to the ETS engine's Vernier point map. A `home` request walks the phase back to index 0 before a new sweep.

---
 rtl/ets_pkg.sv | 25 ++
 rtl/ets_phase_stepper_if.sv | 28 ++
 rtl/ets_phase_counter.sv | 34 +++
 rtl/ets_phase_stepper.sv | 142 ++++++++++++++
 tb/tb_ets_phase_stepper.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ets_pkg.sv
// Shared types and helpers for the ETS phase-control blocks: FSM state and
// request-mode enums, the default fine-step count per period, and a width helper.
package ets_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    WAIT  = 3'd2,
    DWELL = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_HOME  = 1'b1
  } mode_t;

  localparam int PHASE_WRAP_DEFAULT = 448;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int ets_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ets_phase_stepper_if.sv
// Request/done handshake with the ETS engine plus the MMCM dynamic phase-shift
// port, bundled so the stepper and its drivers share one connection.
interface ets_phase_stepper_if;

  logic        shift;
  logic        shift_done;
  logic        home;
  logic        home_done;
  logic        psen;
  logic        psincdec;
  logic        psdone;
  logic [31:0] vernier_q;
  logic        busy;
  logic        err_timeout;

  // Requester side: the ETS engine together with the MMCM phase-shift port.
  modport master (
    output shift, home, psdone,
    input  shift_done, home_done, psen, psincdec, vernier_q, busy, err_timeout
  );

  // Stepper side.
  modport slave (
    input  shift, home, psdone,
    output shift_done, home_done, psen, psincdec, vernier_q, busy, err_timeout
  );

endinterface

// File: rtl/ets_phase_counter.sv
// Modulo-PHASE_WRAP up/down fine-phase index with enable and synchronous clear;
// shared by the phase stepper and later sweep controllers.
module ets_phase_counter
  import ets_pkg::*;
#(
  parameter  int PHASE_WRAP = PHASE_WRAP_DEFAULT,
  localparam int Q_W        = ets_width(PHASE_WRAP)
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           en,
  input  logic           up,
  output logic [Q_W-1:0] q
);

  localparam logic [Q_W-1:0] Q_TOP = Q_W'(PHASE_WRAP - 1);

  function automatic logic [Q_W-1:0] wrap_inc(input logic [Q_W-1:0] v);
    return (v == Q_TOP) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [Q_W-1:0] wrap_dec(input logic [Q_W-1:0] v);
    return (v == '0) ? Q_TOP : v - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= up ? wrap_inc(q) : wrap_dec(q);
    end
  end

endmodule

// File: rtl/ets_phase_stepper.sv
// ETS sampling-clock fine-phase stepper driving the MMCM PSEN/PSINCDEC/PSDONE port.
// Build option ETS_DWELL_EN inserts a DWELL_CYCLES settle period before each done pulse.
module ets_phase_stepper
  import ets_pkg::*;
#(
  parameter int STEPS_PER_SHIFT = 1,
  parameter int PHASE_WRAP      = PHASE_WRAP_DEFAULT,
  parameter int PSDONE_TIMEOUT  = 64,
  parameter int DWELL_CYCLES    = 16
) (
  input logic               clk,
  input logic               reset,
  ets_phase_stepper_if.slave bus
);

  localparam int Q_W     = ets_width(PHASE_WRAP);
  localparam int STEP_W  = ets_width(STEPS_PER_SHIFT + 1);
  localparam int REM_W   = (Q_W > STEP_W) ? Q_W : STEP_W;
  localparam int CNT_MAX = (PSDONE_TIMEOUT > DWELL_CYCLES) ? PSDONE_TIMEOUT : DWELL_CYCLES;
  localparam int CNT_W   = ets_width(CNT_MAX + 1);

  localparam logic [REM_W-1:0] STEPS_INIT   = REM_W'(STEPS_PER_SHIFT);
  localparam logic [REM_W-1:0] REM_LAST     = REM_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PSDONE_TIMEOUT - 1);
`ifdef ETS_DWELL_EN
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
`endif

  state_t           state, state_nx;
  mode_t            mode, mode_nx;
  logic             dir, dir_nx;
  logic [REM_W-1:0] rem, rem_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err, err_nx;
  logic             step_en;
  logic [Q_W-1:0]   q;

  ets_phase_counter #(
    .PHASE_WRAP (PHASE_WRAP)
  ) u_counter (
    .clk   (clk),
    .clear (reset),
    .en    (step_en),
    .up    (dir),
    .q     (q)
  );

  // cnt is the psdone timeout counter in WAIT and the settle counter in DWELL.
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    dir_nx   = dir;
    rem_nx   = rem;
    cnt_nx   = cnt;
    err_nx   = err;
    step_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.home) begin
          mode_nx  = MODE_HOME;
          dir_nx   = 1'b0;
          rem_nx   = REM_W'(q);
          state_nx = (q == '0) ? DONE : STEP;
        end else if (bus.shift) begin
          mode_nx  = MODE_SHIFT;
          dir_nx   = 1'b1;
          rem_nx   = STEPS_INIT;
          state_nx = STEP;
        end
      end
      STEP: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // A psdone landing on the final timeout cycle still counts as success.
        if (bus.psdone) begin
          step_en = 1'b1;
          rem_nx  = rem - 1'b1;
          cnt_nx  = '0;
          if (rem == REM_LAST) begin
`ifdef ETS_DWELL_EN
            state_nx = DWELL;
`else
            state_nx = DONE;
`endif
          end else begin
            state_nx = STEP;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`ifdef ETS_DWELL_EN
      DWELL: begin
        if (cnt == DWELL_LAST) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`endif
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mode  <= MODE_SHIFT;
      dir   <= 1'b0;
      rem   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      mode  <= mode_nx;
      dir   <= dir_nx;
      rem   <= rem_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end
  end

  // Every output is a decode of registered state, so none glitch on inputs.
  assign bus.psen        = (state == STEP);
  assign bus.psincdec    = dir;
  assign bus.busy        = (state != IDLE);
  assign bus.shift_done  = (state == DONE) && (mode == MODE_SHIFT);
  assign bus.home_done   = (state == DONE) && (mode == MODE_HOME);
  assign bus.err_timeout = err;
  assign bus.vernier_q   = 32'(q);

endmodule

// File: tb/tb_ets_phase_stepper.sv
// Scoreboard bench for ets_phase_stepper: one single-step instance and one
// four-step instance, each answered by a small MMCM phase-shift model.
`timescale 1ns/1ps
module tb_ets_phase_stepper;

`ifdef ETS_DWELL_EN
  localparam int DONE_LAT = 17;
`else
  localparam int DONE_LAT = 1;
`endif

  typedef struct {
    bit          is_home;
    logic [31:0] q;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  ets_phase_stepper_if ifa ();
  ets_phase_stepper_if ifb ();

  bit pd_a = 1'b0, pdx_a = 1'b0, pd_b = 1'b0;
  assign ifa.psdone = pd_a | pdx_a;
  assign ifb.psdone = pd_b;

  ets_phase_stepper #(
    .STEPS_PER_SHIFT (1),
    .PHASE_WRAP      (448),
    .PSDONE_TIMEOUT  (64),
    .DWELL_CYCLES    (16)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (ifa)
  );

  ets_phase_stepper #(
    .STEPS_PER_SHIFT (4),
    .PHASE_WRAP      (448),
    .PSDONE_TIMEOUT  (64),
    .DWELL_CYCLES    (16)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (ifb)
  );

  int psen_a = 0, inc_a = 0, dec_a = 0, sdone_a = 0, hdone_a = 0;
  int psen_cyc_a = 0, psdone_cyc_a = 0, done_cyc_a = 0, req_cyc_a = 0;
  int cd_a = 0, lat_a = 12, give_a = -1;

  int psen_b = 0, inc_b = 0, dec_b = 0, sdone_b = 0, hdone_b = 0;
  int psdone_cyc_b = 0, done_cyc_b = 0;
  int cd_b = 0, lat_b = 2, give_b = -1;

  // MMCM model + done scoreboard, instance A
  always @(negedge clk) begin
    exp_t e;
    pd_a = 1'b0;
    if (reset_a) begin
      cd_a = 0;
    end else begin
      if (ifa.psen) begin
        psen_a++;
        if (ifa.psincdec) inc_a++; else dec_a++;
        psen_cyc_a = cyc;
        checks++;
        if (cd_a != 0) begin
          errors++;
          $display("FAIL psen_overlap_a: psen with %0d cycles of psdone still pending, required 0", cd_a);
        end
        if (give_a != 0) begin
          cd_a = lat_a;
          if (give_a > 0) give_a--;
        end
      end else if (cd_a != 0) begin
        cd_a--;
        if (cd_a == 0) begin
          pd_a = 1'b1;
          psdone_cyc_a = cyc;
        end
      end
      if (ifa.shift_done || ifa.home_done) begin
        done_cyc_a = cyc;
        if (ifa.shift_done) sdone_a++;
        if (ifa.home_done) hdone_a++;
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_unexpected: done pulse shift=%0b home=%0b, required none", ifa.shift_done, ifa.home_done);
        end else begin
          e = sb_a.pop_front();
          if (ifa.home_done !== e.is_home || ifa.shift_done !== !e.is_home || ifa.vernier_q !== e.q) begin
            errors++;
            $display("FAIL sb_a: home_done=%0b shift_done=%0b vernier_q=%0d, required home_done=%0b vernier_q=%0d",
                     ifa.home_done, ifa.shift_done, ifa.vernier_q, e.is_home, e.q);
          end
        end
      end
    end
  end

  // MMCM model + done scoreboard, instance B
  always @(negedge clk) begin
    exp_t e;
    pd_b = 1'b0;
    if (reset_b) begin
      cd_b = 0;
    end else begin
      if (ifb.psen) begin
        psen_b++;
        if (ifb.psincdec) inc_b++; else dec_b++;
        checks++;
        if (cd_b != 0) begin
          errors++;
          $display("FAIL psen_overlap_b: psen with %0d cycles of psdone still pending, required 0", cd_b);
        end
        if (give_b != 0) begin
          cd_b = lat_b;
          if (give_b > 0) give_b--;
        end
      end else if (cd_b != 0) begin
        cd_b--;
        if (cd_b == 0) begin
          pd_b = 1'b1;
          psdone_cyc_b = cyc;
        end
      end
      if (ifb.shift_done || ifb.home_done) begin
        done_cyc_b = cyc;
        if (ifb.shift_done) sdone_b++;
        if (ifb.home_done) hdone_b++;
        checks++;
        if (sb_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_unexpected: done pulse shift=%0b home=%0b, required none", ifb.shift_done, ifb.home_done);
        end else begin
          e = sb_b.pop_front();
          if (ifb.home_done !== e.is_home || ifb.shift_done !== !e.is_home || ifb.vernier_q !== e.q) begin
            errors++;
            $display("FAIL sb_b: home_done=%0b shift_done=%0b vernier_q=%0d, required home_done=%0b vernier_q=%0d",
                     ifb.home_done, ifb.shift_done, ifb.vernier_q, e.is_home, e.q);
          end
        end
      end
    end
  end

  task automatic pulse_a(input bit s, input bit h);
    @(posedge clk); #1;
    ifa.shift = s;
    ifa.home  = h;
    req_cyc_a = cyc;
    @(posedge clk); #1;
    ifa.shift = 1'b0;
    ifa.home  = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge clk); #1;
    ifb.shift = 1'b1;
    @(posedge clk); #1;
    ifb.shift = 1'b0;
  endtask

  task automatic wait_done_a(input int base, input int limit, input string tag);
    int n;
    n = 0;
    while (sdone_a + hdone_a == base && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sdone_a + hdone_a == base) begin
      errors++;
      $display("FAIL %s: no done pulse after %0d cycles, required one", tag, limit);
    end
  endtask

  task automatic wait_done_b(input int base, input int limit, input string tag);
    int n;
    n = 0;
    while (sdone_b + hdone_b == base && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sdone_b + hdone_b == base) begin
      errors++;
      $display("FAIL %s: no done pulse after %0d cycles, required one", tag, limit);
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifa.busy, ifa.psen, ifa.psincdec} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/psen/psincdec=%b, required 000", {ifa.busy, ifa.psen, ifa.psincdec});
    end
    checks++;
    if ({ifa.shift_done, ifa.home_done, ifa.err_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: shift_done/home_done/err_timeout=%b, required 000",
               {ifa.shift_done, ifa.home_done, ifa.err_timeout});
    end
    checks++;
    if (ifa.vernier_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_vernier: vernier_q=%0d, required 0", ifa.vernier_q);
    end
    checks++;
    if ({ifb.busy, ifb.psen, ifb.err_timeout} !== 3'b000 || ifb.vernier_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: busy/psen/err=%b vernier_q=%0d, required 000 and 0",
               {ifb.busy, ifb.psen, ifb.err_timeout}, ifb.vernier_q);
    end
    @(posedge clk); #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
  endtask

  task automatic test_basic_step();
    int base, p0, i0;
    base = sdone_a + hdone_a;
    p0 = psen_a;
    i0 = inc_a;
    sb_a.push_back('{1'b0, 32'd1});
    pulse_a(1'b1, 1'b0);
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b, required 1", ifa.busy);
    end
    wait_done_a(base, 200, "basic_done");
    checks++;
    if (psen_a - p0 != 1 || inc_a - i0 != 1) begin
      errors++;
      $display("FAIL basic_psen: psen pulses=%0d increments=%0d, required 1 and 1", psen_a - p0, inc_a - i0);
    end
    checks++;
    if (psen_cyc_a - req_cyc_a != 1) begin
      errors++;
      $display("FAIL basic_psen_lat: psen %0d cycles after request, required 1", psen_cyc_a - req_cyc_a);
    end
    checks++;
    if (done_cyc_a - psdone_cyc_a != DONE_LAT) begin
      errors++;
      $display("FAIL basic_done_lat: shift_done %0d cycles after psdone, required %0d",
               done_cyc_a - psdone_cyc_a, DONE_LAT);
    end
    checks++;
    if (ifa.vernier_q !== 32'd1) begin
      errors++;
      $display("FAIL basic_vernier: vernier_q=%0d, required 1", ifa.vernier_q);
    end
  endtask

  task automatic test_home();
    int base, p0, i0, d0, s0;
    for (int k = 2; k <= 5; k++) begin
      base = sdone_a + hdone_a;
      sb_a.push_back('{1'b0, 32'(k)});
      pulse_a(1'b1, 1'b0);
      wait_done_a(base, 200, "home_preload");
    end
    base = sdone_a + hdone_a;
    p0 = psen_a; i0 = inc_a; d0 = dec_a; s0 = sdone_a;
    sb_a.push_back('{1'b1, 32'd0});
    pulse_a(1'b0, 1'b1);
    wait_done_a(base, 400, "home_done");
    checks++;
    if (psen_a - p0 != 5 || dec_a - d0 != 5 || inc_a - i0 != 0) begin
      errors++;
      $display("FAIL home_steps: psen=%0d dec=%0d inc=%0d, required 5 5 0", psen_a - p0, dec_a - d0, inc_a - i0);
    end
    checks++;
    if (sdone_a != s0 || ifa.vernier_q !== 32'd0) begin
      errors++;
      $display("FAIL home_result: extra shift_done=%0d vernier_q=%0d, required 0 and 0", sdone_a - s0, ifa.vernier_q);
    end
    base = sdone_a + hdone_a;
    p0 = psen_a;
    sb_a.push_back('{1'b1, 32'd0});
    pulse_a(1'b0, 1'b1);
    wait_done_a(base, 20, "home_zero_done");
    checks++;
    if (psen_a != p0 || done_cyc_a - req_cyc_a < 1 || done_cyc_a - req_cyc_a > 2) begin
      errors++;
      $display("FAIL home_zero: psen=%0d done_lat=%0d, required 0 psen and latency 1..2",
               psen_a - p0, done_cyc_a - req_cyc_a);
    end
  endtask

  task automatic test_timeout();
    int base, p0;
    give_a = 0;
    base = sdone_a + hdone_a;
    p0 = psen_a;
    sb_a.push_back('{1'b0, 32'd0});
    pulse_a(1'b1, 1'b0);
    wait_done_a(base, 300, "timeout_done");
    checks++;
    if (ifa.err_timeout !== 1'b1 || ifa.vernier_q !== 32'd0 || psen_a - p0 != 1) begin
      errors++;
      $display("FAIL timeout: err_timeout=%b vernier_q=%0d psen=%0d, required 1 0 1",
               ifa.err_timeout, ifa.vernier_q, psen_a - p0);
    end
    give_a = -1;
    base = sdone_a + hdone_a;
    sb_a.push_back('{1'b0, 32'd1});
    pulse_a(1'b1, 1'b0);
    wait_done_a(base, 200, "timeout_recover");
    checks++;
    if (ifa.err_timeout !== 1'b1 || ifa.vernier_q !== 32'd1) begin
      errors++;
      $display("FAIL timeout_sticky: err_timeout=%b vernier_q=%0d, required 1 and 1", ifa.err_timeout, ifa.vernier_q);
    end
  endtask

  task automatic test_collisions();
    int base, i0, d0, s0;
    base = sdone_a + hdone_a;
    i0 = inc_a; d0 = dec_a; s0 = sdone_a;
    sb_a.push_back('{1'b1, 32'd0});
    pulse_a(1'b1, 1'b1);
    wait_done_a(base, 200, "collide_done");
    repeat (5) @(negedge clk);
    checks++;
    if (sdone_a != s0 || inc_a != i0 || dec_a - d0 != 1) begin
      errors++;
      $display("FAIL collide: shift_done=%0d inc=%0d dec=%0d, required 0 0 1", sdone_a - s0, inc_a - i0, dec_a - d0);
    end
    @(posedge clk); #1;
    pdx_a = 1'b1;
    @(posedge clk); #1;
    pdx_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.vernier_q !== 32'd0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_psdone: vernier_q=%0d busy=%b, required 0 and 0", ifa.vernier_q, ifa.busy);
    end
    base = sdone_a + hdone_a;
    s0 = sdone_a;
    sb_a.push_back('{1'b0, 32'd1});
    pulse_a(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop_busy: busy=%b, required 1", ifa.busy);
    end
    ifa.shift = 1'b1;
    @(posedge clk); #1;
    ifa.shift = 1'b0;
    wait_done_a(base, 200, "busy_drop_done");
    repeat (40) @(negedge clk);
    checks++;
    if (sdone_a - s0 != 1 || ifa.vernier_q !== 32'd1) begin
      errors++;
      $display("FAIL busy_drop: shift_done=%0d vernier_q=%0d, required 1 and 1", sdone_a - s0, ifa.vernier_q);
    end
  endtask

  task automatic test_reset_mid_wait();
    int base;
    base = sdone_a + hdone_a;
    pulse_a(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ifa.busy !== 1'b1 || ifa.psincdec !== 1'b1) begin
      errors++;
      $display("FAIL midwait_pre: busy=%b psincdec=%b, required 1 and 1", ifa.busy, ifa.psincdec);
    end
    reset_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ifa.busy, ifa.psen, ifa.psincdec, ifa.shift_done, ifa.home_done, ifa.err_timeout} !== 6'b0 ||
        ifa.vernier_q !== 32'd0) begin
      errors++;
      $display("FAIL midwait_reset: outputs=%b vernier_q=%0d, required 000000 and 0",
               {ifa.busy, ifa.psen, ifa.psincdec, ifa.shift_done, ifa.home_done, ifa.err_timeout}, ifa.vernier_q);
    end
    reset_a = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (sdone_a + hdone_a != base) begin
      errors++;
      $display("FAIL midwait_nodone: done pulses=%0d, required 0", sdone_a + hdone_a - base);
    end
  endtask

  task automatic test_multi_step_wrap();
    int base, p0, i0, s0;
    give_b = 2;
    base = sdone_b + hdone_b;
    sb_b.push_back('{1'b0, 32'd2});
    pulse_b();
    wait_done_b(base, 400, "wrap_partial");
    checks++;
    if (ifb.err_timeout !== 1'b1 || ifb.vernier_q !== 32'd2) begin
      errors++;
      $display("FAIL wrap_partial: err_timeout=%b vernier_q=%0d, required 1 and 2", ifb.err_timeout, ifb.vernier_q);
    end
    give_b = -1;
    for (int k = 1; k <= 111; k++) begin
      base = sdone_b + hdone_b;
      sb_b.push_back('{1'b0, 32'((2 + 4 * k) % 448)});
      pulse_b();
      wait_done_b(base, 200, "wrap_preload");
    end
    checks++;
    if (ifb.vernier_q !== 32'd446) begin
      errors++;
      $display("FAIL wrap_preload: vernier_q=%0d, required 446", ifb.vernier_q);
    end
    base = sdone_b + hdone_b;
    p0 = psen_b; i0 = inc_b; s0 = sdone_b;
    sb_b.push_back('{1'b0, 32'd2});
    pulse_b();
    wait_done_b(base, 300, "wrap_done");
    repeat (5) @(negedge clk);
    checks++;
    if (psen_b - p0 != 4 || inc_b - i0 != 4 || sdone_b - s0 != 1 || ifb.vernier_q !== 32'd2) begin
      errors++;
      $display("FAIL wrap: psen=%0d inc=%0d shift_done=%0d vernier_q=%0d, required 4 4 1 2",
               psen_b - p0, inc_b - i0, sdone_b - s0, ifb.vernier_q);
    end
    checks++;
    if (done_cyc_b - psdone_cyc_b != DONE_LAT) begin
      errors++;
      $display("FAIL wrap_done_lat: shift_done %0d cycles after last psdone, required %0d",
               done_cyc_b - psdone_cyc_b, DONE_LAT);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.shift = 1'b0;
    ifa.home  = 1'b0;
    ifb.shift = 1'b0;
    ifb.home  = 1'b0;
    reset_a   = 1'b1;
    reset_b   = 1'b1;
    test_reset();
    test_basic_step();
    test_home();
    test_timeout();
    test_collisions();
    test_reset_mid_wait();
    test_multi_step_wrap();
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: pending a=%0d b=%0d, required 0 and 0", sb_a.size(), sb_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
